// File: rtl/arm_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arm_mem_pkg -- shared types and constants for mem_arbiter (rev 1.0) |
// +--------------------------------------------------------------------+
package arm_mem_pkg;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } requester_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } arb_state_e;

  localparam int MEM_LAT_MAX = 15;
  localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX + 1);

endpackage
`default_nettype wire

// File: rtl/arb_pick2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arb_pick2 -- two-way one-hot request picker (rev 1.0)              |
// +--------------------------------------------------------------------+
module arb_pick2
  import arm_mem_pkg::*;
(
  input  logic       req_cpu_i,
  input  logic       req_dbg_i,
  input  requester_e last_i,
  input  logic       rr_en_i,
  output logic [1:0] gnt_o
);

  // gnt_o bit index matches the requester_e encoding
  always_comb begin
    gnt_o = 2'b00;
    if (req_cpu_i && req_dbg_i) begin
      if (rr_en_i && (last_i == REQ_CPU)) begin
        gnt_o = 2'b10;
      end else begin
        gnt_o = 2'b01;
      end
    end else if (req_cpu_i) begin
      gnt_o = 2'b01;
    end else if (req_dbg_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arbiter -- CPU/debug arbiter onto one synchronous memory port.  |
// | Define ARB_ROUND_ROBIN_EN for round-robin ties (rev 1.0).           |
// +--------------------------------------------------------------------+
module mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_adr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT);
  localparam logic [LAT_CNT_W-1:0] CNT_LAST = LAT_CNT_W'(1);

  arb_state_e           state_q;
  requester_e           owner_q;
  logic                 we_q;
  logic [ADDR_W-1:0]    adr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [LAT_CNT_W-1:0] cnt_q;
  logic [DATA_W-1:0]    cpu_rdata_q;
  logic [DATA_W-1:0]    dbg_rdata_q;

  logic       in_idle;
  logic       in_access;
  logic [1:0] pick;
  logic [1:0] grant;
  requester_e grant_id;
  requester_e last_w;
  logic       rr_en;
  logic       wr_done;
  logic       rd_done;

  arb_pick2 u_pick (
    .req_cpu_i (cpu_req),
    .req_dbg_i (dbg_req),
    .last_i    (last_w),
    .rr_en_i   (rr_en),
    .gnt_o     (pick)
  );

  // Grant is combinational, so it is also masked by reset to stay quiet while held
  assign in_idle   = (state_q == ST_IDLE) && reset;
  assign in_access = (state_q == ST_ACCESS);
  assign grant     = pick & {2{in_idle}};
  assign grant_id  = grant[1] ? REQ_DBG : REQ_CPU;

`ifdef ARB_ROUND_ROBIN_EN
  requester_e last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= REQ_DBG;
    end else if (|grant) begin
      last_q <= grant_id;
    end
  end

  assign last_w = last_q;
  assign rr_en  = 1'b1;
`else
  assign last_w = REQ_DBG;
  assign rr_en  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= REQ_CPU;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            owner_q <= grant_id;
            we_q    <= (grant_id == REQ_DBG) ? dbg_we    : cpu_we;
            adr_q   <= (grant_id == REQ_DBG) ? dbg_adr   : cpu_adr;
            wdata_q <= (grant_id == REQ_DBG) ? dbg_wdata : cpu_wdata;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (we_q) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q   <= LAT_LOAD;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) begin
            if (owner_q == REQ_DBG) begin
              dbg_rdata_q <= mem_rdata;
            end else begin
              cpu_rdata_q <= mem_rdata;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_done = in_access && we_q;
  assign rd_done = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);

  assign cpu_gnt  = grant[0];
  assign dbg_gnt  = grant[1];
  assign cpu_done = (wr_done || rd_done) && (owner_q == REQ_CPU);
  assign dbg_done = (wr_done || rd_done) && (owner_q == REQ_DBG);

  // Read data is forwarded in the completion cycle; the register holds it afterwards
  assign cpu_rdata = (rd_done && (owner_q == REQ_CPU)) ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata = (rd_done && (owner_q == REQ_DBG)) ? mem_rdata : dbg_rdata_q;

  assign mem_en    = in_access;
  assign mem_we    = in_access && we_q;
  assign mem_adr   = in_access ? adr_q   : '0;
  assign mem_wdata = in_access ? wdata_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_arbiter -- scoreboard bench, instance 0 MEM_LAT=1, 1 = 4     |
// +--------------------------------------------------------------------+
module tb_mem_arbiter;
  import arm_mem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NI = 2;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    int            cyc;
    logic          port;
    logic          we;
    logic [DW-1:0] rdata;
  } done_exp_t;

  logic clk = 1'b0;
  logic rst_n [NI];
  logic cpu_req [NI], cpu_we [NI], cpu_gnt [NI], cpu_done [NI];
  logic dbg_req [NI], dbg_we [NI], dbg_gnt [NI], dbg_done [NI];
  logic [AW-1:0] cpu_adr [NI], dbg_adr [NI], mem_adr [NI];
  logic [DW-1:0] cpu_wdata [NI], dbg_wdata [NI], mem_wdata [NI];
  logic [DW-1:0] cpu_rdata [NI], dbg_rdata [NI];
  logic mem_en [NI], mem_we [NI];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  mem_exp_t      mem_q  [NI][$];
  done_exp_t     done_q [NI][$];
  logic [DW-1:0] hold   [NI][2];
  logic [DW-1:0] shadow [NI][256];

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int g);
    return (g == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [DW-1:0] mdl [256];
    int            mcnt;
    logic [DW-1:0] mdat;
    logic [DW-1:0] mrd;

    assign mrd = (mcnt == 1) ? mdat : 32'hBAD0BAD0;

    always @(posedge clk) begin
      if (cyc == 0) begin
        for (int i = 0; i < 256; i++)
          mdl[i] <= (i == 'h40) ? 32'hDEADBEEF : (32'h5A000000 | 32'(i));
        mcnt <= 0;
      end else begin
        if (mem_en[g] && mem_we[g]) mdl[mem_adr[g][9:2]] <= mem_wdata[g];
        if (mem_en[g] && !mem_we[g]) begin
          mcnt <= lat(g);
          mdat <= mdl[mem_adr[g][9:2]];
        end else if (mcnt > 0) begin
          mcnt <= mcnt - 1;
        end
      end
    end

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(g == 0 ? 1 : 4)) u_dut (
      .clk       (clk),
      .reset     (rst_n[g]),
      .cpu_req   (cpu_req[g]),
      .cpu_we    (cpu_we[g]),
      .cpu_adr   (cpu_adr[g]),
      .cpu_wdata (cpu_wdata[g]),
      .cpu_gnt   (cpu_gnt[g]),
      .cpu_done  (cpu_done[g]),
      .cpu_rdata (cpu_rdata[g]),
      .dbg_req   (dbg_req[g]),
      .dbg_we    (dbg_we[g]),
      .dbg_adr   (dbg_adr[g]),
      .dbg_wdata (dbg_wdata[g]),
      .dbg_gnt   (dbg_gnt[g]),
      .dbg_done  (dbg_done[g]),
      .dbg_rdata (dbg_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_adr   (mem_adr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mrd)
    );

    always @(negedge clk) begin
      if (rst_n[g] === 1'b1) mon(g);
    end
  end

  task automatic mon(input int g);
    mem_exp_t  me;
    done_exp_t de;
    if (mem_en[g]) begin
      if (mem_q[g].size() == 0) begin
        chk("mem_unexpected", 64'(mem_en[g]), 0);
      end else begin
        me = mem_q[g].pop_front();
        chk("mem_cycle", 64'(cyc), 64'(me.cyc));
        chk("mem_we", 64'(mem_we[g]), 64'(me.we));
        chk("mem_adr", 64'(mem_adr[g]), 64'(me.adr));
        chk("mem_wdata", 64'(mem_wdata[g]), 64'(me.wdata));
      end
    end else begin
      chk("mem_idle_bus", {31'd0, mem_we[g], mem_adr[g] | mem_wdata[g]}, 0);
    end
    if (cpu_done[g] && dbg_done[g]) begin
      chk("done_both", {62'd0, cpu_done[g], dbg_done[g]}, 64'd1);
    end else if (cpu_done[g] || dbg_done[g]) begin
      if (done_q[g].size() == 0) begin
        chk("done_unexpected", {62'd0, cpu_done[g], dbg_done[g]}, 0);
      end else begin
        de = done_q[g].pop_front();
        chk("done_cycle", 64'(cyc), 64'(de.cyc));
        chk("done_port", 64'(dbg_done[g]), 64'(de.port));
        if (!de.we) hold[g][de.port] = de.rdata;
      end
    end
    chk("cpu_rdata", 64'(cpu_rdata[g]), 64'(hold[g][0]));
    chk("dbg_rdata", 64'(dbg_rdata[g]), 64'(hold[g][1]));
  endtask

  task automatic push(input int g, input logic port, input logic we,
                      input logic [AW-1:0] adr, input logic [DW-1:0] wd, input int t);
    mem_exp_t  me;
    done_exp_t de;
    me.cyc = t + 1; me.we = we; me.adr = adr; me.wdata = wd;
    mem_q[g].push_back(me);
    de.cyc = we ? t + 1 : t + 1 + lat(g);
    de.port = port; de.we = we; de.rdata = shadow[g][adr[9:2]];
    if (we) shadow[g][adr[9:2]] = wd;
    done_q[g].push_back(de);
  endtask

  task automatic set_req(input int g, input logic port, input logic rq, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] wd);
    if (port) begin
      dbg_req[g] = rq; dbg_we[g] = we; dbg_adr[g] = adr; dbg_wdata[g] = wd;
    end else begin
      cpu_req[g] = rq; cpu_we[g] = we; cpu_adr[g] = adr; cpu_wdata[g] = wd;
    end
  endtask

  task automatic issue(input int g, input logic port, input logic we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] wd, output int tr, output int t);
    bit got;
    got = 1'b0;
    t = -1;
    @(posedge clk); #1;
    tr = cyc;
    set_req(g, port, 1'b1, we, adr, wd);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (port ? dbg_gnt[g] : cpu_gnt[g]) begin
        got = 1'b1;
        t = cyc;
        push(g, port, we, adr, wd, cyc);
      end
    end
    if (!got) chk("gnt_timeout", 64'(port ? dbg_gnt[g] : cpu_gnt[g]), 64'd1);
    @(posedge clk); #1;
    set_req(g, port, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic drain(input int g);
    for (int i = 0; i < 60 && (mem_q[g].size() != 0 || done_q[g].size() != 0); i++)
      @(negedge clk);
    chk("drain", 64'(done_q[g].size() + mem_q[g].size()), 0);
  endtask

  task automatic chk_quiet(input int g, input string tag);
    chk({tag, "_ctl"}, {58'd0, cpu_gnt[g], cpu_done[g], dbg_gnt[g], dbg_done[g], mem_en[g], mem_we[g]}, 0);
    chk({tag, "_bus"}, 64'(mem_adr[g] | mem_wdata[g]), 0);
    chk({tag, "_rdata"}, 64'(cpu_rdata[g] | dbg_rdata[g]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int tr, t, tr2, t2;
    logic ep;
    for (int g = 0; g < NI; g++) begin
      rst_n[g] = 1'b0;
      for (int i = 0; i < 256; i++)
        shadow[g][i] = (i == 'h40) ? 32'hDEADBEEF : (32'h5A000000 | 32'(i));
      hold[g][0] = '0;
      hold[g][1] = '0;
      set_req(g, REQ_CPU, 1'b1, 1'b0, 32'h100, '0);
      set_req(g, REQ_DBG, 1'b1, 1'b1, 32'h40, 32'h1);
    end

    // Reset state, with requests held to show grants stay low
    repeat (2) @(negedge clk);
    chk_quiet(0, "reset0");
    chk_quiet(1, "reset1");
    for (int g = 0; g < NI; g++) begin
      set_req(g, REQ_CPU, 1'b0, 1'b0, '0, '0);
      set_req(g, REQ_DBG, 1'b0, 1'b0, '0, '0);
    end
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Lone CPU read, latency 1
    issue(0, REQ_CPU, 1'b0, 32'h100, '0, tr, t);
    chk("cpu_rd_gnt_time", 64'(t), 64'(tr));
    drain(0);

    // DBG write, then read it back
    issue(0, REQ_DBG, 1'b1, 32'h40, 32'h12345678, tr, t);
    chk("dbg_wr_gnt_time", 64'(t), 64'(tr));
    drain(0);
    issue(0, REQ_DBG, 1'b0, 32'h40, '0, tr, t);
    drain(0);

    // Both requesting back-to-back writes
    @(posedge clk); #1;
    set_req(0, REQ_CPU, 1'b1, 1'b1, 32'h200, 32'h11110000);
    set_req(0, REQ_DBG, 1'b1, 1'b1, 32'h300, 32'h22220000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ep = RR ? ((k % 2) != 0) : 1'b0;
      chk("tie_gnt", {62'd0, cpu_gnt[0], dbg_gnt[0]}, ep ? 64'd1 : 64'd2);
      if (ep) push(0, REQ_DBG, 1'b1, 32'h300, 32'h22220000, cyc);
      else    push(0, REQ_CPU, 1'b1, 32'h200, 32'h11110000, cyc);
      @(negedge clk);
      chk("gnt_in_access", {62'd0, cpu_gnt[0], dbg_gnt[0]}, 0);
    end
    @(posedge clk); #1;
    set_req(0, REQ_CPU, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("dbg_after_cpu_drop", {62'd0, cpu_gnt[0], dbg_gnt[0]}, 64'd1);
    push(0, REQ_DBG, 1'b1, 32'h300, 32'h22220000, cyc);
    @(posedge clk); #1;
    set_req(0, REQ_DBG, 1'b0, 1'b0, '0, '0);
    drain(0);

    // Latency 4: dbg raised two cycles after the cpu grant waits for IDLE
    issue(1, REQ_CPU, 1'b0, 32'h100, '0, tr, t);
    issue(1, REQ_DBG, 1'b1, 32'h80, 32'hCAFEF00D, tr2, t2);
    chk("dbg_req_cycle", 64'(tr2), 64'(t + 2));
    chk("dbg_gnt_after_wait", 64'(t2), 64'(t + 6));
    drain(1);

    // Reset in the middle of WAIT
    issue(1, REQ_CPU, 1'b0, 32'h100, '0, tr, t);
    @(posedge clk); #1;
    @(posedge clk); #1;
    set_req(1, REQ_DBG, 1'b1, 1'b0, 32'h80, '0);
    rst_n[1] = 1'b0;
    #1;
    chk_quiet(1, "rst_wait");
    mem_q[1].delete();
    done_q[1].delete();
    hold[1][0] = '0;
    hold[1][1] = '0;
    @(posedge clk); #1;
    set_req(1, REQ_DBG, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    repeat (8) @(negedge clk);
    issue(1, REQ_DBG, 1'b0, 32'h80, '0, tr, t);
    chk("post_reset_gnt_time", 64'(t), 64'(tr));
    drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width.
REQ-002 Parameter: DATA_W, 32, data width.
REQ-003 Parameter: MEM_LAT, 1, cycles from read issue to valid mem_rdata; legal range 1..15.
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Ports: cpu_req in 1, cpu_we in 1, cpu_adr in ADDR_W, cpu_wdata in DATA_W  CPU request; held stable until cpu_gnt.
REQ-007 Ports: cpu_gnt out 1, cpu_done out 1, cpu_rdata out DATA_W  CPU grant pulse, completion pulse, read data.
REQ-008 Ports: dbg_req, dbg_we, dbg_adr, dbg_wdata, dbg_gnt, dbg_done, dbg_rdata  debug/loader requester; same widths and rules as the CPU port.
REQ-009 Ports: mem_en out 1, mem_we out 1, mem_adr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W  single shared synchronous memory port.

Function
REQ-010 FSM states: IDLE, ACCESS, WAIT.
REQ-011 In IDLE, a request present in cycle T: winner's gnt=1 in T (combinational); its we/adr/wdata and identity are latched at the end of T; next state ACCESS.
REQ-012 Losing or absent requester: gnt=0; a losing request stays pending and is not dropped.
REQ-013 ACCESS (T+1): mem_en=1; mem_we/mem_adr/mem_wdata from the latch; exactly one cycle.
REQ-014 Write in ACCESS: winner's done=1 in T+1; next state IDLE.
REQ-015 Read in ACCESS: 4-bit latency counter loaded with MEM_LAT; next state WAIT.
REQ-016 WAIT: counter decrements each cycle; in cycle T+1+MEM_LAT, mem_rdata is captured into the winner's rdata register, winner's done=1, next state IDLE.
REQ-017 Outside ACCESS: mem_en=0, mem_we=0, mem_adr/mem_wdata=0.
REQ-018 rdata registers hold until the next read completion for the same port; a write never alters them.
REQ-019 gnt is asserted only in IDLE; requests in ACCESS/WAIT are ignored until IDLE.
REQ-020 Per port: at most one gnt and one done per transaction; the two ports never get done in the same cycle.
REQ-021 Peak throughput: one write per 2 cycles; one read per MEM_LAT+2 cycles.

Reset
REQ-022 reset low: FSM to IDLE, counter=0, latches=0, cpu_rdata=dbg_rdata=0, last-winner=DBG, all gnt/done/mem_* outputs 0, immediately, independent of clk.
REQ-023 Reset during ACCESS/WAIT aborts the transaction; no done is issued for it after reset release.
REQ-024 First edge after release: normal IDLE arbitration.

Configuration
REQ-025 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the port not granted last; last-winner register updates on every grant.
REQ-026 Macro undefined: fixed priority, CPU always wins ties; no last-winner register is built.

Structure
REQ-027 Package arm_mem_pkg: requester enum (REQ_CPU, REQ_DBG), FSM state enum, MEM_LAT_MAX=15, latency counter width constant.
REQ-028 Sub-module arb_pick2: combinational 2-way picker (requests, last winner, rr-enable) -> one-hot grant.

Verification
REQ-029 CPU read alone, adr=0x100, MEM_LAT=1, memory returns 0xDEADBEEF -> cpu_gnt at T, mem_en at T+1, cpu_done with cpu_rdata=0xDEADBEEF at T+2.
REQ-030 DBG write adr=0x40, wdata=0x12345678 -> dbg_gnt T, mem_en=mem_we=1 at T+1 with those values, dbg_done T+1, dbg_rdata unchanged.
REQ-031 Both requesting continuously, with ARB_ROUND_ROBIN_EN -> grants CPU,DBG,CPU,DBG; without it -> CPU only, DBG granted only after cpu_req drops.
REQ-032 MEM_LAT=4 read -> done exactly at T+5; a dbg_req raised at T+2 is granted no earlier than T+6.
REQ-033 reset low during WAIT -> all outputs 0 that same cycle; no done after release; next request served normally.
